column_array: RTL and testbench
===============================

Name: column_array

Overview:
- Parametrised multi-column falling-letter engine; successor to the single-column block.
- Manages NUM_COLS independent columns sharing one fall prescaler, with LFSR letter generation and staggered spawn/respawn.
- Keystroke strobes are arbitrated to the most-endangered matching column; the block also keeps a saturating score and a game-over latch.
- Sits between the keyboard decoder (user_input/input_valid) and the display/score renderer.

Parameters:
- NUM_COLS, 4: number of columns, 1..8.
- ROWS, 22: bottom row; an active letter at ypos == ROWS ends the game.
- FALL_TICKS, 50000000: clock cycles per fall step, minimum 2.
- RESPAWN_TICKS, 3: fall steps a column stays empty after a hit, minimum 1.
- LETTER_W, 8: letter width, at most 16.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_signal_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a game.
- user_input  in  LETTER_W  keystroke code.
- input_valid  in  1  one-cycle strobe qualifying user_input.
- ypos  out  NUM_COLS*YW  per-column row; column i occupies bits [i*YW +: YW]; YW = $clog2(ROWS+1).
- letter  out  NUM_COLS*LETTER_W  per-column letter; column i occupies bits [i*LETTER_W +: LETTER_W].
- active  out  NUM_COLS  column currently holds a falling letter.
- hit  out  1  one-cycle pulse: a keystroke matched a column.
- hit_col  out  3  index of the matched column; valid while hit = 1.
- miss  out  1  one-cycle pulse: a keystroke matched nothing.
- score  out  16  hit count, saturating.
- game_over  out  1  high while in state OVER.

Behaviour:
- Reset (async, reset_signal_n = 0):
  - State READY; ypos, letter, active, hit, hit_col, miss, score, game_over all 0.
  - Prescaler 0; respawn counters 0; LFSR = 16'hACE1.
- LFSR:
  - 16-bit Galois, taps 16,14,13,11 (mask 16'hB400).
  - Advances every clock in every state, never 0.
  - A spawned letter is lfsr[LETTER_W-1:0] sampled in the spawn cycle.
- Global FSM:
  - READY: no motion; input_valid ignored. start -> RUN.
  - RUN: game active, per the rules below.
  - OVER: everything frozen; outputs hold; input_valid ignored. start -> RUN.
  - start in RUN restarts the game.
  - Every entry to RUN: score = 0, all active = 0, ypos = 0, prescaler = 0, respawn counter of column i = i+1, game_over = 0. Takes effect the cycle after start.
- Prescaler (RUN only):
  - Counts 0..FALL_TICKS-1.
  - tick = 1 in the cycle the count equals FALL_TICKS-1; the count then wraps to 0.
- On tick, per column:
  - Active column: ypos+1.
  - Inactive column: respawn counter -1. When the counter reaches 0: active = 1, ypos = 0, letter = LFSR (visible next cycle).
- Game over: if after a tick any active column has ypos == ROWS, go to OVER next cycle; game_over = 1 and ypos holds ROWS.
- Hit arbitration (RUN, input_valid = 1):
  - Candidates are active columns whose letter equals user_input.
  - Winner is the candidate with the largest ypos; on a tie, the lowest index wins.
  - Next cycle for the winner: active = 0, ypos = 0, respawn counter = RESPAWN_TICKS; hit = 1, hit_col = winner, score +1, saturating at 16'hFFFF.
  - No candidate: miss = 1 for one cycle; no other effect.
- Simultaneous events:
  - Hit and tick in the same cycle: the winner does not advance; the tick applies to all other columns.
  - A hit in the same cycle that a tick would carry the winner to ROWS prevents game over for that column.
  - start has priority over input_valid and tick.
- Latency:
  - Keystroke to hit/miss: 1 cycle.
  - Tick to ypos update: 1 cycle.
  - Reaching ROWS to game_over: 1 cycle.
- Duplicate letters across columns are allowed; arbitration resolves them.

Test Plan (NUM_COLS=2, ROWS=4, FALL_TICKS=3, RESPAWN_TICKS=2, LETTER_W=8):
- Reset, then idle 20 cycles -> all outputs 0; LFSR advancing visible through first spawned letter after start.
- start, wait -> column 0 active after 1st tick (cycle 3), column 1 after 2nd tick (cycle 6); each ypos increments every 3 cycles.
- input_valid with column 1's letter -> next cycle hit = 1, hit_col = 1, score = 1, active[1] = 0; column 1 respawns after 2 ticks.
- Both columns loaded with the same letter (force LFSR/seed) at ypos 2 and 1 -> hit_col = 0; at equal ypos -> hit_col = 0.
- No keystrokes -> column 0 reaches ypos 4 -> game_over = 1 next cycle; further ticks and keystrokes change nothing; start -> score 0, game_over 0.
- Keystroke with an unmatched code -> miss = 1 for exactly 1 cycle, score unchanged.
- Keystroke in the tick cycle with column 0 at ypos 3 -> hit, no game over.
- reset_signal_n asserted mid-RUN -> outputs 0 immediately (asynchronous).
- score preloaded to 16'hFFFF then hit -> score stays 16'hFFFF.

Source files
------------

// File: rtl/column_array.sv
// column_array: multi-column falling-letter engine.
//
// NUM_COLUMNS style columns (NUM_COLS) share one fall prescaler. Each column
// spawns a letter taken from a free-running 16-bit Galois LFSR, lets it fall
// one row per prescaler tick, and empties again when a keystroke hits it.
// Keystrokes go to the matching column whose letter is lowest on screen.
// A letter that reaches the bottom row ends the game.
//
// Ports:
//   clock           system clock, all state changes on the rising edge
//   reset_signal_n  asynchronous active-low reset
//   start           one-cycle pulse, begins or restarts a game
//   user_input      keystroke code (LETTER_W bits)
//   input_valid     one-cycle strobe qualifying user_input
//   ypos            per-column row, column i at [i*YW +: YW]
//   letter          per-column letter, column i at [i*LETTER_W +: LETTER_W]
//   active          per-column "holds a falling letter"
//   hit / hit_col   one-cycle hit pulse and index of the column that was hit
//   miss            one-cycle pulse, keystroke matched no column
//   score           saturating hit count
//   game_over       high while the game is over
module column_array #(
  parameter int NUM_COLS      = 4,
  parameter int ROWS          = 22,
  parameter int FALL_TICKS    = 50000000,
  parameter int RESPAWN_TICKS = 3,
  parameter int LETTER_W      = 8,
  localparam int YW           = $clog2(ROWS + 1)
) (
  input  logic                         clock,
  input  logic                         reset_signal_n,
  input  logic                         start,
  input  logic [LETTER_W-1:0]          user_input,
  input  logic                         input_valid,
  output logic [NUM_COLS*YW-1:0]       ypos,
  output logic [NUM_COLS*LETTER_W-1:0] letter,
  output logic [NUM_COLS-1:0]          active,
  output logic                         hit,
  output logic [2:0]                   hit_col,
  output logic                         miss,
  output logic [15:0]                  score,
  output logic                         game_over
);

  localparam int PW       = $clog2(FALL_TICKS);
  localparam int RESP_MAX = (RESPAWN_TICKS > NUM_COLS) ? RESPAWN_TICKS : NUM_COLS;
  localparam int RW       = $clog2(RESP_MAX + 1);

  typedef enum logic [1:0] {
    READY = 2'd0,
    RUN   = 2'd1,
    OVER  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [15:0]     lfsr_reg, lfsr_next;
  logic [PW-1:0]   pres_reg, pres_next;
  logic [15:0]     score_reg, score_next;
  logic            hit_reg, hit_next;
  logic            miss_reg, miss_next;
  logic [2:0]      hit_col_reg, hit_col_next;

  logic [NUM_COLS-1:0] at_rows;
  logic                reached;
  logic                run_live;
  logic                tick;
  logic                key;
  logic                win_valid;
  logic [2:0]          win_idx;
  logic [YW-1:0]       win_y;

  // A letter sitting on the bottom row freezes the game for the one cycle
  // in which the transition to OVER is being made: no motion, no keystrokes.
  assign reached  = |at_rows;
  assign run_live = (state_reg == RUN) && !reached && !start;
  assign tick     = run_live && (pres_reg == PW'(FALL_TICKS - 1));
  assign key      = run_live && input_valid;

  // Winner search: strict '>' while scanning upward keeps the lowest index
  // on equal rows.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_y     = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (key && active[i] && (letter[i*LETTER_W +: LETTER_W] == user_input) &&
          (!win_valid || (ypos[i*YW +: YW] > win_y))) begin
        win_valid = 1'b1;
        win_idx   = 3'(i);
        win_y     = ypos[i*YW +: YW];
      end
    end
  end

  // Global state, prescaler, score and strobes.
  always_comb begin
    state_next   = state_reg;
    pres_next    = pres_reg;
    score_next   = score_reg;
    hit_next     = 1'b0;
    miss_next    = 1'b0;
    hit_col_next = hit_col_reg;
    lfsr_next    = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);

    if (start) begin
      state_next = RUN;
      pres_next  = '0;
      score_next = '0;
    end else begin
      case (state_reg)
        READY, OVER: begin
        end
        RUN: begin
          if (reached) begin
            state_next = OVER;
          end else begin
            pres_next = tick ? '0 : pres_reg + PW'(1);
            if (key) begin
              if (win_valid) begin
                hit_next     = 1'b1;
                hit_col_next = win_idx;
                if (score_reg != 16'hFFFF) begin
                  score_next = score_reg + 16'd1;
                end
              end else begin
                miss_next = 1'b1;
              end
            end
          end
        end
        default: state_next = READY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_signal_n) begin
    if (!reset_signal_n) begin
      state_reg   <= READY;
      lfsr_reg    <= 16'hACE1;
      pres_reg    <= '0;
      score_reg   <= '0;
      hit_reg     <= 1'b0;
      miss_reg    <= 1'b0;
      hit_col_reg <= '0;
    end else begin
      state_reg   <= state_next;
      lfsr_reg    <= lfsr_next;
      pres_reg    <= pres_next;
      score_reg   <= score_next;
      hit_reg     <= hit_next;
      miss_reg    <= miss_next;
      hit_col_reg <= hit_col_next;
    end
  end

  // Per-column state.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
      logic [YW-1:0]       ypos_reg, ypos_next;
      logic [LETTER_W-1:0] letter_reg, letter_next;
      logic                active_reg, active_next;
      logic [RW-1:0]       resp_reg, resp_next;
      logic                is_win;

      assign is_win = win_valid && (win_idx == 3'(gi));

      always_comb begin
        ypos_next   = ypos_reg;
        letter_next = letter_reg;
        active_next = active_reg;
        resp_next   = resp_reg;
        if (start) begin
          // Staggered first spawn: column i appears on tick i+1.
          active_next = 1'b0;
          ypos_next   = '0;
          resp_next   = RW'(gi + 1);
        end else if (is_win) begin
          // A hit overrides a coincident tick for this column.
          active_next = 1'b0;
          ypos_next   = '0;
          resp_next   = RW'(RESPAWN_TICKS);
        end else if (tick) begin
          if (active_reg) begin
            ypos_next = ypos_reg + YW'(1);
          end else if (resp_reg == RW'(1)) begin
            active_next = 1'b1;
            ypos_next   = '0;
            letter_next = lfsr_reg[LETTER_W-1:0];
            resp_next   = '0;
          end else begin
            resp_next = resp_reg - RW'(1);
          end
        end
      end

      always_ff @(posedge clock or negedge reset_signal_n) begin
        if (!reset_signal_n) begin
          ypos_reg   <= '0;
          letter_reg <= '0;
          active_reg <= 1'b0;
          resp_reg   <= '0;
        end else begin
          ypos_reg   <= ypos_next;
          letter_reg <= letter_next;
          active_reg <= active_next;
          resp_reg   <= resp_next;
        end
      end

      assign ypos[gi*YW +: YW]             = ypos_reg;
      assign letter[gi*LETTER_W +: LETTER_W] = letter_reg;
      assign active[gi]                    = active_reg;
      assign at_rows[gi]                   = active_reg && (ypos_reg == YW'(ROWS));
    end
  endgenerate

  assign hit       = hit_reg;
  assign hit_col   = hit_col_reg;
  assign miss      = miss_reg;
  assign score     = score_reg;
  assign game_over = (state_reg == OVER);

endmodule

// File: tb/tb_column_array.sv
// Randomised scoreboard bench for column_array. A behavioural game model
// predicts the visible outputs for the next clock edge whenever stimulus is
// applied; a monitor compares them one cycle later. Letters are kept narrow
// so duplicate letters (and equal-row ties) across columns occur often.
module tb_column_array;
  localparam int NC   = 2;
  localparam int ROWS = 4;
  localparam int FT   = 3;
  localparam int RT   = 2;
  localparam int LW   = 2;
  localparam int YW   = $clog2(ROWS + 1);
  localparam int NCYC = 3000;
  localparam int MIDRST = 1700;

  logic                 clock = 1'b0;
  logic                 reset_signal_n = 1'b0;
  logic                 start = 1'b0;
  logic [LW-1:0]        user_input = '0;
  logic                 input_valid = 1'b0;
  logic [NC*YW-1:0]     ypos;
  logic [NC*LW-1:0]     letter;
  logic [NC-1:0]        active;
  logic                 hit;
  logic [2:0]           hit_col;
  logic                 miss;
  logic [15:0]          score;
  logic                 game_over;

  column_array #(
    .NUM_COLS(NC), .ROWS(ROWS), .FALL_TICKS(FT),
    .RESPAWN_TICKS(RT), .LETTER_W(LW)
  ) dut (
    .clock(clock), .reset_signal_n(reset_signal_n), .start(start),
    .user_input(user_input), .input_valid(input_valid),
    .ypos(ypos), .letter(letter), .active(active), .hit(hit),
    .hit_col(hit_col), .miss(miss), .score(score), .game_over(game_over)
  );

  always #5 clock = ~clock;

  // Model of the game: 0 = waiting, 1 = playing, 2 = finished.
  int            m_state;
  int            m_ypos[NC];
  logic [LW-1:0] m_letter[NC];
  bit            m_active[NC];
  int            m_resp[NC];
  int            m_pres;
  int            m_score;
  logic [15:0]   m_lfsr;
  bit            m_hit, m_miss;
  int            m_hit_col;

  typedef struct {
    logic [NC*YW-1:0] ypos;
    logic [NC*LW-1:0] letter;
    logic [NC-1:0]    active;
    logic             hit;
    logic [2:0]       hit_col;
    logic             miss;
    logic [15:0]      score;
    logic             go;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic model_reset();
    m_state = 0; m_pres = 0; m_score = 0; m_lfsr = 16'hACE1;
    m_hit = 0; m_miss = 0; m_hit_col = 0;
    for (int i = 0; i < NC; i++) begin
      m_ypos[i] = 0; m_letter[i] = '0; m_active[i] = 0; m_resp[i] = 0;
    end
  endtask

  // One clock of the game rules, given the inputs present at that edge.
  task automatic model_step(input logic st, input logic iv, input logic [LW-1:0] ui);
    logic [15:0] lf_now;
    bit          bottom, tk;
    int          win;
    lf_now = m_lfsr;
    m_lfsr = lfsr_adv(m_lfsr);
    m_hit  = 0;
    m_miss = 0;
    if (st) begin
      m_state = 1; m_score = 0; m_pres = 0;
      for (int i = 0; i < NC; i++) begin
        m_active[i] = 0; m_ypos[i] = 0; m_resp[i] = i + 1;
      end
    end else if (m_state == 1) begin
      bottom = 0;
      for (int i = 0; i < NC; i++) if (m_active[i] && m_ypos[i] == ROWS) bottom = 1;
      if (bottom) begin
        m_state = 2;
      end else begin
        tk = (m_pres == FT - 1);
        m_pres = tk ? 0 : m_pres + 1;
        win = -1;
        if (iv) begin
          for (int i = 0; i < NC; i++)
            if (m_active[i] && m_letter[i] == ui && (win < 0 || m_ypos[i] > m_ypos[win]))
              win = i;
          if (win >= 0) begin
            m_hit = 1; m_hit_col = win;
            if (m_score < 65535) m_score++;
          end else begin
            m_miss = 1;
          end
        end
        for (int i = 0; i < NC; i++) begin
          if (i == win) begin
            m_active[i] = 0; m_ypos[i] = 0; m_resp[i] = RT;
          end else if (tk) begin
            if (m_active[i]) m_ypos[i]++;
            else begin
              m_resp[i]--;
              if (m_resp[i] == 0) begin
                m_active[i] = 1; m_ypos[i] = 0; m_letter[i] = lf_now[LW-1:0];
              end
            end
          end
        end
      end
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    for (int i = 0; i < NC; i++) begin
      e.ypos[i*YW +: YW]   = YW'(m_ypos[i]);
      e.letter[i*LW +: LW] = m_letter[i];
      e.active[i]          = m_active[i];
    end
    e.hit     = m_hit;
    e.hit_col = 3'(m_hit_col);
    e.miss    = m_miss;
    e.score   = 16'(m_score);
    e.go      = (m_state == 2);
    return e;
  endfunction

  task automatic check(input exp_t e, input bit chk_col, input string tag);
    bit bad = 0;
    vectors++;
    if (ypos !== e.ypos) begin bad = 1; $display("FAIL %s ypos got %h want %h", tag, ypos, e.ypos); end
    if (letter !== e.letter) begin bad = 1; $display("FAIL %s letter got %h want %h", tag, letter, e.letter); end
    if (active !== e.active) begin bad = 1; $display("FAIL %s active got %b want %b", tag, active, e.active); end
    if (hit !== e.hit) begin bad = 1; $display("FAIL %s hit got %b want %b", tag, hit, e.hit); end
    if ((chk_col || e.hit) && hit_col !== e.hit_col) begin
      bad = 1; $display("FAIL %s hit_col got %0d want %0d", tag, hit_col, e.hit_col);
    end
    if (miss !== e.miss) begin bad = 1; $display("FAIL %s miss got %b want %b", tag, miss, e.miss); end
    if (score !== e.score) begin bad = 1; $display("FAIL %s score got %0d want %0d", tag, score, e.score); end
    if (game_over !== e.go) begin bad = 1; $display("FAIL %s game_over got %b want %b", tag, game_over, e.go); end
    if (bad) miscompares++;
  endtask

  // Monitor: one expected entry per clock edge while the game is out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e, 1'b0, "cycle");
        if (e.hit)  $display("t=%0t hit col=%0d score=%0d", $time, e.hit_col, e.score);
        if (e.miss) $display("t=%0t miss score=%0d", $time, e.score);
      end
    end
  end

  initial begin
    logic          st, iv;
    logic [LW-1:0] ui;
    int            rate;
    model_reset();
    repeat (3) @(negedge clock);
    check(snapshot(), 1'b1, "reset");
    reset_signal_n = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc != 0) @(negedge clock);
      if (cyc == MIDRST) begin
        // Asynchronous reset mid-game: outputs must clear before any edge.
        reset_signal_n = 1'b0;
        start = 1'b0; input_valid = 1'b0;
        #1;
        model_reset();
        check(snapshot(), 1'b1, "async_reset");
        repeat (3) @(negedge clock);
        reset_signal_n = 1'b1;
      end
      // Busy typing for a while, then sparse typing so letters reach the bottom.
      rate = ((cyc / 400) % 2 == 0) ? 3 : 20;
      if (cyc < 20 || (cyc >= MIDRST && cyc < MIDRST + 20)) st = 1'b0;
      else if (cyc == 20 || cyc == MIDRST + 20) st = 1'b1;
      else st = ($urandom_range(99, 0) == 0);
      iv = ($urandom_range(rate - 1, 0) == 0);
      if ($urandom_range(3, 0) != 0) ui = m_letter[$urandom_range(NC - 1, 0)];
      else ui = LW'($urandom);
      start = st; input_valid = iv; user_input = ui;
      model_step(st, iv, ui);
      sb.push_back(snapshot());
    end
    @(negedge clock);
    start = 1'b0; input_valid = 1'b0;
    repeat (2) @(negedge clock);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain queue left %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
